// File: rtl/router_input_buffer_if.sv
// Link/arbiter-side signal bundle of one router input port.
// master = upstream link plus arbiter, slave = the input buffer.
interface router_input_buffer_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 3
);
    logic [DATA_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic              grant;
    logic [DATA_W-1:0] out_flit;
    logic              out_valid;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              req;
    logic              drop_err;
    logic [AW:0]       count;

    modport master (
        output in_flit, in_valid, grant,
        input  in_ready, out_flit, out_valid, flit_id, length, req, drop_err, count
    );

    modport slave (
        input  in_flit, in_valid, grant,
        output in_ready, out_flit, out_valid, flit_id, length, req, drop_err, count
    );
endinterface

// File: rtl/router_input_buffer.sv
// Per-port input FIFO of the 5-port router: buffers link flits, decodes the head
// flit for the port arbiter and drops stray non-header flits arriving between packets.
module router_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    router_input_buffer_if.slave  bus
);
    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [2:0]  ID_HEAD    = 3'b001;
    localparam logic [2:0]  ID_TAIL    = 3'b100;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count_q;
    state_t            state;
    logic              drop_q;

    logic [DATA_W-1:0] head;
    logic [2:0]        head_id;
    logic              empty;
    logic              full;
    logic              stray;
    logic              push;
    logic              pop;

    always_comb begin
        head    = mem[rd_ptr];
        empty   = (count_q == '0);
        full    = (count_q == FULL_COUNT);
        head_id = empty ? 3'b000 : head[DATA_W-1:DATA_W-3];
        // Anything but a header at the head while idle cannot start a packet; discard it.
        stray   = (state == IDLE) && !empty && (head_id != ID_HEAD);
        push    = bus.in_valid && !full;
        pop     = !empty && (bus.grant || stray);
    end

    assign bus.in_ready  = !full;
    assign bus.out_flit  = head;
    assign bus.out_valid = !empty;
    assign bus.flit_id   = head_id;
    assign bus.length    = (head_id == ID_HEAD) ? head[11:0] : '0;
    // Held through the whole packet, even while momentarily empty, so the arbiter keeps the port.
    assign bus.req       = (state == PKT) || (head_id == ID_HEAD);
    assign bus.drop_err  = drop_q;
    assign bus.count     = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            state   <= IDLE;
            drop_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            drop_q <= pop && stray;
            case (state)
                IDLE: begin
                    if (pop && head_id == ID_HEAD) begin
                        state <= PKT;
                    end
                end
                PKT: begin
                    if (pop && head_id == ID_TAIL) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based packet model.
module tb_router_input_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    router_input_buffer_if #(.DATA_W(32), .AW(3)) bus ();

    router_input_buffer #(.DATA_W(32), .DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [31:0] q[$];
    bit          m_pkt  = 1'b0;
    bit          m_drop = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] id);
        logic [28:0] payload;
        payload = 29'($urandom);
        return {id, payload};
    endfunction

    function automatic logic [31:0] mk_head(input logic [11:0] len);
        logic [16:0] payload;
        payload = 17'($urandom);
        return {3'b001, payload, len};
    endfunction

    // One clock: drive inputs, compare every output with the model, advance the model.
    task automatic cyc(input logic v, input logic [31:0] f, input logic g);
        logic        hv;
        logic [31:0] hd;
        logic [2:0]  id;
        logic        stray_e;
        logic        pop_e;
        logic        push_e;
        int          sz;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_flit  = f;
        bus.grant    = g;
        #1;
        sz      = q.size();
        hv      = (sz != 0);
        hd      = hv ? q[0] : 32'h0;
        id      = hv ? hd[31:29] : 3'b000;
        stray_e = !m_pkt && hv && (id != 3'b001);
        check("out_valid", 32'(bus.out_valid), 32'(hv));
        if (hv) check("out_flit", bus.out_flit, hd);
        check("flit_id", 32'(bus.flit_id), 32'(id));
        check("length", 32'(bus.length), (id == 3'b001) ? {20'h0, hd[11:0]} : 32'h0);
        check("req", 32'(bus.req), 32'(m_pkt || id == 3'b001));
        check("in_ready", 32'(bus.in_ready), 32'(sz != 8));
        check("count", 32'(bus.count), 32'(sz));
        check("drop_err", 32'(bus.drop_err), 32'(m_drop));
        pop_e  = hv && (g || stray_e);
        push_e = v && (sz != 8);
        m_drop = pop_e && stray_e;
        if (pop_e) begin
            void'(q.pop_front());
            if (id == 3'b001) m_pkt = 1'b1;
            else if (id == 3'b100) m_pkt = 1'b0;
        end
        if (push_e) q.push_back(f);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.grant    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.grant    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_pkt  = 1'b0;
        m_drop = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_flit  = '0;
        bus.grant    = 1'b0;

        // Reset values, then a 4-flit packet buffered and drained.
        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_req", 32'(bus.req), 32'd0);
        check("rst_drop", 32'(bus.drop_err), 32'd0);
        check("rst_flit_id", 32'(bus.flit_id), 32'd0);
        check("rst_length", 32'(bus.length), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        cyc(1'b1, mk_head(12'd5), 1'b0);
        cyc(1'b1, mk(3'b010), 1'b0);
        cyc(1'b1, mk(3'b010), 1'b0);
        cyc(1'b1, mk(3'b100), 1'b0);
        check("t1_count", 32'(bus.count), 32'd4);
        check("t1_req", 32'(bus.req), 32'd1);
        check("t1_flit_id", 32'(bus.flit_id), 32'd1);
        check("t1_length", 32'(bus.length), 32'd5);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
        check("t1_req_end", 32'(bus.req), 32'd0);
        check("t1_count_end", 32'(bus.count), 32'd0);

        // Fill to capacity, refused push, and push+pop while full.
        do_reset();
        cyc(1'b1, mk_head(12'd7), 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, mk(3'b010), 1'b0);
        check("t2_count_full", 32'(bus.count), 32'd8);
        check("t2_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b1, mk(3'b010), 1'b0);
        check("t2_count_refused", 32'(bus.count), 32'd8);
        cyc(1'b1, mk(3'b010), 1'b1);
        check("t2_count_pushpop", 32'(bus.count), 32'd7);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 1'b1);

        // Stray body flit while idle is dropped without grant.
        do_reset();
        cyc(1'b1, mk(3'b010), 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        check("t3_drop_pulse", 32'(bus.drop_err), 32'd1);
        check("t3_req", 32'(bus.req), 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        check("t3_drop_clear", 32'(bus.drop_err), 32'd0);

        // Underrun mid-packet keeps req asserted until the tail.
        do_reset();
        cyc(1'b1, mk_head(12'd3), 1'b1);
        cyc(1'b1, mk(3'b010), 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        check("t4_req_gap", 32'(bus.req), 32'd1);
        check("t4_valid_gap", 32'(bus.out_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, mk(3'b100), 1'b1);
        check("t4_valid_tail", 32'(bus.out_valid), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        check("t4_req_end", 32'(bus.req), 32'd0);

        // Reset mid-packet discards stored flits.
        do_reset();
        cyc(1'b1, mk_head(12'd9), 1'b0);
        cyc(1'b1, mk(3'b010), 1'b0);
        cyc(1'b1, mk(3'b010), 1'b0);
        check("t5_count_pre", 32'(bus.count), 32'd3);
        do_reset();
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_req", 32'(bus.req), 32'd0);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);

        // Pointer wrap-around under a continuous stream.
        do_reset();
        cyc(1'b1, mk_head(12'd20), 1'b1);
        for (int i = 0; i < 18; i++) cyc(1'b1, mk(3'b010), 1'b1);
        cyc(1'b1, mk(3'b100), 1'b1);
        check("t6_count", 32'(bus.count), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        check("t6_req_end", 32'(bus.req), 32'd0);

        // Random traffic including unknown ids, grant gaps and occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [2:0]  id;
            logic        v;
            logic        g;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                id = (r < 3) ? 3'b001 : (r < 7) ? 3'b010 : (r < 9) ? 3'b100 : 3'b011;
                v = ($urandom_range(0, 99) < 60);
                g = ($urandom_range(0, 99) < 50);
                cyc(v, (id == 3'b001) ? mk_head(12'($urandom)) : mk(id), g);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
